mem_dw_ctrl: RTL and testbench
==============================

Name: mem_dw_ctrl

Overview:
- Memory-side controller between the 64-bit processor datapath and the 1024x32 testbench memory.
- Accepts one 64-bit read or write request per handshake.
- Splits each request into two sequenced 32-bit memory accesses: low word, then high word.
- Drives the memory's active-low CS_/RD_/WR_ strobes, its address, and the bidirectional 32-bit data bus.

Parameters:
- MEM_AW, 10, memory word-address width; CPU double-word address is MEM_AW-1 bits.
- WAIT_STATES, 0, extra cycles each half-access holds its strobes before completing (0..7).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Rst_  input  1  asynchronous, active-low reset.
- Req  input  1  request strobe, sampled only in IDLE.
- WrEn  input  1  1 = write, 0 = read; sampled with Req.
- CpuAddr  input  MEM_AW-1  double-word address.
- WrData  input  64  write data, sampled with Req.
- RdData  output  64  read data, valid when Ack=1 for a read; holds until next read completes.
- Ack  output  1  one-cycle completion pulse.
- Busy  output  1  high whenever state != IDLE.
- MemCS_  output  1  memory chip select, active-low.
- MemRD_  output  1  memory read enable, active-low.
- MemWR_  output  1  memory write enable, active-low.
- MemAddr  output  MEM_AW  memory word address.
- MemData  inout  32  bidirectional memory data bus.

Behaviour:
- Reset (Rst_=0, async, also mid-operation):
  - State=IDLE; Ack=0, Busy=0, RdData=0, MemAddr=0.
  - MemCS_=MemRD_=MemWR_=1; MemData driver released to hi-z.
  - Any in-flight access is abandoned; a half-written double-word is permitted.
- All outputs are registered with nonblocking updates, so the memory samples the previous cycle's strobes at each edge.
- States: IDLE -> LO -> HI -> ACK -> IDLE.
- IDLE:
  - On Req=1, latch WrEn, CpuAddr, WrData; go to LO.
  - Req=0: stay in IDLE.
- LO:
  - MemAddr={addr,1'b0}; MemCS_=0.
  - Read: MemRD_=0, MemWR_=1, MemData hi-z.
  - Write: MemWR_=0, MemRD_=1, MemData driven with WrData[31:0].
  - Wait counter loads WAIT_STATES and decrements each cycle; the state exits when the counter is 0.
  - Read: on the exit edge, capture MemData into RdData[31:0].
- HI:
  - Same as LO with MemAddr={addr,1'b1}.
  - Data is WrData[63:32] on writes; MemData is captured into RdData[63:32] on reads.
- ACK:
  - Strobes all 1 and MemData hi-z (one-cycle bus turnaround).
  - Ack=1 for exactly this cycle; next state IDLE.
- Latency: Req accepted at edge t -> Ack high during cycle t+3+2*WAIT_STATES.
  - Minimum request-to-request spacing is 4 cycles at WAIT_STATES=0.
- Req while Busy=1 is ignored (not queued); the requester must hold Req until it sees Ack, then re-request.
- Req held continuously: a new request is accepted on the edge leaving IDLE after ACK, i.e. one idle cycle between transactions.
- MemData is never driven while MemRD_=0; controller drive and memory drive are mutually exclusive in all states.
- Address range: CpuAddr max (all ones) maps to memory words 2^MEM_AW-2 and 2^MEM_AW-1; no wrap or carry into other words.
- RdData is not modified by writes.

Test Plan:
- Write CpuAddr=9'h005, WrData=64'hDEADBEEF_01234567 -> memarray[10]=32'h01234567, memarray[11]=32'hDEADBEEF; Ack exactly 3 cycles after acceptance; MemWR_ low for exactly 2 cycles.
- Read CpuAddr=9'h005 after that write -> RdData=64'hDEADBEEF_01234567 when Ack=1; MemData never driven by the controller while MemRD_=0.
- Req held high for 3 back-to-back transactions -> Ack every 4 cycles; Req pulses during Busy produce no extra access; Busy deasserts one cycle after each Ack.
- WAIT_STATES=2, read of CpuAddr=9'h1FF -> MemAddr=10'h3FE for 3 cycles then 10'h3FF for 3 cycles; Ack at cycle 7.
- Assert Rst_=0 during the HI phase of a write -> same cycle: strobes=1, MemData=z, Ack=0, Busy=0, RdData=0. Low word written, high word unchanged. Next request completes normally.

Source files
------------

// File: rtl/mem_dw_if.sv
// Processor-side request/response bundle for mem_dw_ctrl.
//   master : requester (drives Req, WrEn, CpuAddr, WrData; sees RdData, Ack, Busy)
//   slave  : controller (the reverse)
//   Req     request strobe, sampled by the controller only when idle
//   WrEn    1 = write, 0 = read, sampled with Req
//   CpuAddr double-word address (MEM_AW-1 bits)
//   WrData  64-bit write data, sampled with Req
//   RdData  64-bit read data, valid with Ack on a read, held until the next read
//   Ack     one-cycle completion pulse
//   Busy    high while a request is in progress
interface mem_dw_if #(
  parameter int MEM_AW = 10
);
  logic              Req;
  logic              WrEn;
  logic [MEM_AW-2:0] CpuAddr;
  logic [63:0]       WrData;
  logic [63:0]       RdData;
  logic              Ack;
  logic              Busy;

  modport master (
    output Req, WrEn, CpuAddr, WrData,
    input  RdData, Ack, Busy
  );

  modport slave (
    input  Req, WrEn, CpuAddr, WrData,
    output RdData, Ack, Busy
  );
endinterface

// File: rtl/mem_dw_ctrl.sv
// Double-word memory controller: turns one 64-bit read/write request into two
// sequenced 32-bit accesses (low word at {addr,0}, then high word at {addr,1})
// on an asynchronous-style memory with active-low CS_/RD_/WR_ strobes and a
// shared bidirectional data bus.
// Ports:
//   Clk      system clock, rising edge
//   Rst_     asynchronous active-low reset
//   cpu      processor-side handshake (mem_dw_if.slave)
//   MemCS_   memory chip select, active-low
//   MemRD_   memory read enable, active-low
//   MemWR_   memory write enable, active-low
//   MemAddr  memory word address
//   MemData  bidirectional 32-bit memory data bus
//
// state | meaning
// IDLE  | waiting for Req; strobes inactive, bus released
// LO    | low-word access at {addr,0}, held WAIT_STATES extra cycles
// HI    | high-word access at {addr,1}, held WAIT_STATES extra cycles
// ACK   | strobes inactive, bus released (turnaround), Ack pulse
module mem_dw_ctrl #(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              Clk,
  input  logic              Rst_,
  mem_dw_if.slave           cpu,
  output logic              MemCS_,
  output logic              MemRD_,
  output logic              MemWR_,
  output logic [MEM_AW-1:0] MemAddr,
  inout  wire  [31:0]       MemData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t            state_q;
  logic              wr_q;
  logic [MEM_AW-2:0] addr_q;
  logic [63:0]       wdata_q;
  logic [2:0]        cnt_q;
  logic              oe_q;
  logic [31:0]       dout_q;
  logic [63:0]       rdata_q;
  logic              ack_q;
  logic              busy_q;

  // The bus is only ever driven from a registered enable that is set solely
  // for write accesses, so it can never overlap a cycle where MemRD_ is low.
  assign MemData = oe_q ? dout_q : 32'bz;

  assign cpu.RdData = rdata_q;
  assign cpu.Ack    = ack_q;
  assign cpu.Busy   = busy_q;

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      MemCS_  <= 1'b1;
      MemRD_  <= 1'b1;
      MemWR_  <= 1'b1;
      MemAddr <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu.Req) begin
            wr_q    <= cpu.WrEn;
            addr_q  <= cpu.CpuAddr;
            wdata_q <= cpu.WrData;
            cnt_q   <= WS;
            state_q <= S_LO;
            busy_q  <= 1'b1;
            // Strobes for the low word go out with the accept edge so the
            // memory sees them from the first LO cycle.
            MemAddr <= {cpu.CpuAddr, 1'b0};
            MemCS_  <= 1'b0;
            MemRD_  <= cpu.WrEn;
            MemWR_  <= ~cpu.WrEn;
            oe_q    <= cpu.WrEn;
            dout_q  <= cpu.WrData[31:0];
          end
        end

        S_LO: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            if (!wr_q) rdata_q[31:0] <= MemData;
            cnt_q   <= WS;
            state_q <= S_HI;
            MemAddr <= {addr_q, 1'b1};
            dout_q  <= wdata_q[63:32];
          end
        end

        S_HI: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            if (!wr_q) rdata_q[63:32] <= MemData;
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            MemCS_  <= 1'b1;
            MemRD_  <= 1'b1;
            MemWR_  <= 1'b1;
            oe_q    <= 1'b0;
          end
        end

        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dw_ctrl.sv
module tb_mem_dw_ctrl;
  localparam int AW = 10;

  typedef struct {
    logic [63:0] rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  logic          req  [2];
  logic          we   [2];
  logic [AW-2:0] addr [2];
  logic [63:0]   wd   [2];

  mem_dw_if #(.MEM_AW(AW)) if0 ();
  mem_dw_if #(.MEM_AW(AW)) if1 ();

  assign if0.Req = req[0];  assign if0.WrEn = we[0];
  assign if0.CpuAddr = addr[0];  assign if0.WrData = wd[0];
  assign if1.Req = req[1];  assign if1.WrEn = we[1];
  assign if1.CpuAddr = addr[1];  assign if1.WrData = wd[1];

  wire          cs0, rd0, wr0, cs1, rd1, wr1;
  wire [AW-1:0] ma0, ma1;
  wire [31:0]   bus0, bus1;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  int csl0 = 0;
  int wrl0 = 0;

  // Memory model: combinational read drive, write on the edge using the
  // strobes registered in the previous cycle.
  assign bus0 = (!cs0 && !rd0) ? mem0[ma0] : 32'bz;
  assign bus1 = (!cs1 && !rd1) ? mem1[ma1] : 32'bz;

  mem_dw_ctrl #(.MEM_AW(AW), .WAIT_STATES(0)) dut0 (
    .Clk(clk), .Rst_(rst_n), .cpu(if0.slave),
    .MemCS_(cs0), .MemRD_(rd0), .MemWR_(wr0), .MemAddr(ma0), .MemData(bus0)
  );

  mem_dw_ctrl #(.MEM_AW(AW), .WAIT_STATES(2)) dut1 (
    .Clk(clk), .Rst_(rst_n), .cpu(if1.slave),
    .MemCS_(cs1), .MemRD_(rd1), .MemWR_(wr1), .MemAddr(ma1), .MemData(bus1)
  );

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'hA5A5_0000 + 32'(i);
      mem1[i] = 32'hA5A5_0000 + 32'(i);
    end
    forever begin
      @(posedge clk);
      if (!cs0) csl0++;
      if (!cs0 && !wr0) begin
        wrl0++;
        mem0[ma0] = bus0;
      end
      if (!cs1 && !wr1) mem1[ma1] = bus1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i, input logic [63:0] rd);
    exp_t e;
    checks++;
    if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_ack inst%0d: got Ack at cyc %0d expected none", i, cyc);
    end else begin
      if (i == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      chk($sformatf("rddata_inst%0d", i), rd, e.rd);
      chk($sformatf("ack_cycle_inst%0d", i), 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge clk) if (if0.Ack) mon(0, if0.RdData);
  always @(negedge clk) if (if1.Ack) mon(1, if1.RdData);

  // Controller drive must never coincide with a memory read cycle.
  always @(negedge clk) begin
    if (dut0.oe_q && !rd0) viol++;
    if (dut1.oe_q && !rd1) viol++;
    if (!rd0 && !wr0) viol++;
    if (!rd1 && !wr1) viol++;
  end

  task automatic push(input int i, input logic [63:0] rd, input int c);
    exp_t e;
    e.rd  = rd;
    e.cyc = c;
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  function automatic logic get_ack(input int i);
    return (i == 0) ? if0.Ack : if1.Ack;
  endfunction

  task automatic wait_ack(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!get_ack(i) && n < 40);
    if (!get_ack(i)) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout inst%0d: got no Ack after %0d cycles expected Ack", i, n);
    end
  endtask

  task automatic drive(input int i, input logic w, input logic [AW-2:0] a, input logic [63:0] d);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d;
  endtask

  // One full transaction on an idle controller; ws = wait states of that instance.
  task automatic txn(input int i, input int ws, input logic w, input logic [AW-2:0] a,
                     input logic [63:0] d, input logic [63:0] exp_rd);
    @(negedge clk);
    chk($sformatf("idle_before_req_inst%0d", i), 64'((i == 0) ? if0.Busy : if1.Busy), 64'd0);
    drive(i, w, a, d);
    @(posedge clk); #1;
    push(i, exp_rd, cyc + 2 + 2 * ws);
    wait_ack(i);
    req[i] = 1'b0;
  endtask

  initial begin
    int a0, c0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(if0.Busy), 64'd0);
    chk("reset_strobes", {61'd0, cs0, rd0, wr0}, 64'd7);
    chk("reset_rddata", if0.RdData, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write: two strobed cycles, both words land.
    c0 = wrl0;
    txn(0, 0, 1'b1, 9'h005, 64'hDEADBEEF_01234567, 64'd0);
    chk("wr_low_cycles", 64'(wrl0 - c0), 64'd2);
    chk("mem10", 64'(mem0[10]), 64'h01234567);
    chk("mem11", 64'(mem0[11]), 64'hDEADBEEF);

    // Read back.
    txn(0, 0, 1'b0, 9'h005, 64'd0, 64'hDEADBEEF_01234567);

    // Req held through three transactions: accepts every 4 cycles.
    @(negedge clk);
    drive(0, 1'b1, 9'h007, 64'h0BADF00D_CAFE1234);
    @(posedge clk); #1;
    a0 = cyc;
    push(0, 64'hDEADBEEF_01234567, a0 + 2);
    push(0, 64'h0BADF00D_CAFE1234, a0 + 6);
    push(0, 64'hDEADBEEF_01234567, a0 + 10);
    wait_ack(0);
    drive(0, 1'b0, 9'h007, 64'd0);
    @(negedge clk);
    chk("b2b_busy_drop1", 64'(if0.Busy), 64'd0);
    wait_ack(0);
    drive(0, 1'b0, 9'h005, 64'd0);
    @(negedge clk);
    chk("b2b_busy_drop2", 64'(if0.Busy), 64'd0);
    wait_ack(0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_busy_drop3", 64'(if0.Busy), 64'd0);

    // Req pulses while busy must not start another access.
    c0 = csl0;
    @(negedge clk);
    drive(0, 1'b1, 9'h003, 64'h11112222_33334444);
    @(posedge clk); #1;
    push(0, 64'hDEADBEEF_01234567, cyc + 2);
    @(negedge clk);
    drive(0, 1'b1, 9'h004, 64'h55556666_77778888);
    req[0] = 1'b0;
    @(negedge clk);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pulse_idle", 64'(if0.Busy), 64'd0);
    chk("pulse_cs_cycles", 64'(csl0 - c0), 64'd2);
    chk("mem6", 64'(mem0[6]), 64'h33334444);
    chk("mem7", 64'(mem0[7]), 64'h11112222);
    chk("mem8_untouched", 64'(mem0[8]), 64'hA5A50008);
    chk("mem9_untouched", 64'(mem0[9]), 64'hA5A50009);

    // Two wait states, top of the address range.
    txn(1, 2, 1'b1, 9'h1FF, 64'hFEDCBA98_76543210, 64'd0);
    chk("mem1_3fe", 64'(mem1[10'h3FE]), 64'h76543210);
    chk("mem1_3ff", 64'(mem1[10'h3FF]), 64'hFEDCBA98);
    @(negedge clk);
    drive(1, 1'b0, 9'h1FF, 64'd0);
    @(posedge clk); #1;
    push(1, 64'hFEDCBA98_76543210, cyc + 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("ws2_addr_%0d", k), 64'(ma1), (k < 3) ? 64'h3FE : 64'h3FF);
      chk($sformatf("ws2_strobes_%0d", k), {61'd0, cs1, rd1, wr1}, 64'd1);
    end
    wait_ack(1);
    req[1] = 1'b0;

    // Reset during the high-word phase of a write.
    @(negedge clk);
    drive(0, 1'b1, 9'h009, 64'h13579BDF_2468ACE0);
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_hi_addr", 64'(ma0), 64'h013);
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", {61'd0, cs0, rd0, wr0}, 64'd7);
    chk("rst_oe", 64'(dut0.oe_q), 64'd0);
    chk("rst_ack", 64'(if0.Ack), 64'd0);
    chk("rst_busy", 64'(if0.Busy), 64'd0);
    chk("rst_rddata", if0.RdData, 64'd0);
    chk("rst_addr", 64'(ma0), 64'd0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_lo_written", 64'(mem0[18]), 64'h2468ACE0);
    chk("rst_hi_unchanged", 64'(mem0[19]), 64'hA5A50013);
    txn(0, 0, 1'b0, 9'h009, 64'd0, 64'hA5A50013_2468ACE0);

    repeat (3) @(negedge clk);
    chk("bus_contention", 64'(viol), 64'd0);
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
